mem_ctrl: RTL and testbench

//  Memory-side responder for the CPU core. Serves i_fetch requests on RAM port A (read-only).

---
 rtl/mem_ctrl_pkg.sv | 47 ++++
 rtl/mem_ctrl_ls_align.sv | 40 ++++
 rtl/mem_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: width codes, FSM encodings, IO region test bits,
// and the lane-selection helper used by the load/store aligner.
package mem_ctrl_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] WIDTH_B = 2'b00;
   localparam logic [1:0] WIDTH_H = 2'b01;
   localparam logic [1:0] WIDTH_W = 2'b10;

   // IO space is any byte address whose bits [IO_HI:IO_LO] equal IO_TAG
   localparam int unsigned IO_HI  = 17;
   localparam int unsigned IO_LO  = 16;
   localparam logic [1:0]  IO_TAG = 2'b11;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_WAIT = 2'd1,
      IF_DONE = 2'd2
   } if_state_t;

   typedef enum logic [2:0] {
      LS_IDLE  = 3'd0,
      LS_RD    = 3'd1,
      LS_WR    = 3'd2,
      LS_MERGE = 3'd3,
      LS_DONE  = 3'd4
   } ls_state_t;

   // Byte lane of an access; misaligned halves/words are forced down, IO always lane 0
   function automatic logic [1:0] lane_of(input logic [1:0] width,
                                          input logic [1:0] offset,
                                          input logic       io);
      logic [1:0] lane;
      lane = 2'b00;
      if (!io) begin
         case (width)
            WIDTH_B: lane = offset;
            WIDTH_H: lane = {offset[1], 1'b0};
            default: lane = 2'b00;
         endcase
      end
      return lane;
   endfunction

endpackage

// File: rtl/mem_ctrl_ls_align.sv
// Combinational lane logic for mem_ctrl: load extract/extend and sub-word store merge.
module mem_ctrl_ls_align
   import mem_ctrl_pkg::*;
(
   input  logic [1:0]        width,
   input  logic              sgn,
   input  logic              io,
   input  logic [1:0]        offset,
   input  logic [DATA_W-1:0] word,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] load_c,
   output logic [DATA_W-1:0] merge_c
);

   logic [4:0]        sh;
   logic [DATA_W-1:0] lane_word;
   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] mask_sh;

   always_comb begin
      sh        = {lane_of(width, offset, io), 3'b000};
      lane_word = word >> sh;
      load_c    = lane_word;
      mask      = '1;
      case (width)
         WIDTH_B: begin
            mask   = DATA_W'(32'h0000_00FF);
            load_c = {{24{sgn & lane_word[7]}}, lane_word[7:0]};
         end
         WIDTH_H: begin
            mask   = DATA_W'(32'h0000_FFFF);
            load_c = {{16{sgn & lane_word[15]}}, lane_word[15:0]};
         end
         default: ;
      endcase
      mask_sh = mask << sh;
      merge_c = (word & ~mask_sh) | ((wdata << sh) & mask_sh);
   end

endmodule

// File: rtl/mem_ctrl.sv
// Memory-side responder: fetches on RAM port A, loads/stores (with sub-word RMW) on port B.
// Optional MEM_CTRL_RDY_EN adds rdy_in, which freezes the whole block while low.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned MEM_ADDR_WIDTH = ADDR_W,
   parameter int unsigned MEM_DATA_WIDTH = DATA_W
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
`ifdef MEM_CTRL_RDY_EN
   input  logic                      rdy_in,
`endif
   input  logic                      if_valid,
   input  logic [MEM_ADDR_WIDTH-1:0] if_addr,
   input  logic                      if_flush,
   output logic                      if_done,
   output logic [MEM_DATA_WIDTH-1:0] if_data,
   input  logic                      ls_valid,
   input  logic                      ls_we,
   input  logic [1:0]                ls_width,
   input  logic                      ls_signed,
   input  logic [MEM_ADDR_WIDTH-1:0] ls_addr,
   input  logic [MEM_DATA_WIDTH-1:0] ls_wdata,
   output logic                      ls_done,
   output logic [MEM_DATA_WIDTH-1:0] ls_rdata,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_a,
   input  logic [MEM_DATA_WIDTH-1:0] mem_data_a,
   output logic                      mem_wr_b,
   output logic [MEM_DATA_WIDTH-1:0] mem_src_b,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr_b,
   input  logic [MEM_DATA_WIDTH-1:0] mem_data_b
);

   localparam int unsigned AW = MEM_ADDR_WIDTH;
   localparam int unsigned DW = MEM_DATA_WIDTH;

   logic run;
`ifdef MEM_CTRL_RDY_EN
   assign run = rdy_in;
`else
   assign run = 1'b1;
`endif

   // Fetches are word-aligned by contract
   logic unused_if_low;
   assign unused_if_low = ^if_addr[1:0];

   // ---------------- fetch path ----------------
   if_state_t      if_state, if_state_nx;
   logic [AW-1:0]  addr_a_q, addr_a_nx;
   logic [DW-1:0]  if_data_q, if_data_nx;
   logic           if_done_q, if_done_nx;

   always_ff @(posedge clk_in) begin
      if (rst_in)   if_state <= IF_IDLE;
      else if (run) if_state <= if_state_nx;
   end

   always_comb begin
      if_state_nx = if_state;
      case (if_state)
         IF_IDLE: if (if_valid && !if_flush) if_state_nx = IF_WAIT;
         IF_WAIT: if_state_nx = if_flush ? IF_IDLE : IF_DONE;
         IF_DONE: if_state_nx = IF_IDLE;
         default: if_state_nx = IF_IDLE;
      endcase
   end

   always_comb begin
      addr_a_nx  = addr_a_q;
      if_data_nx = if_data_q;
      if_done_nx = 1'b0;
      case (if_state)
         IF_IDLE: if (if_valid && !if_flush) addr_a_nx = {2'b00, if_addr[AW-1:2]};
         IF_WAIT: if (!if_flush) begin
            if_data_nx = mem_data_a;
            if_done_nx = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         addr_a_q  <= '0;
         if_data_q <= '0;
         if_done_q <= 1'b0;
      end else if (run) begin
         addr_a_q  <= addr_a_nx;
         if_data_q <= if_data_nx;
         if_done_q <= if_done_nx;
      end
   end

   // A flush in the done cycle still suppresses the pulse
   assign if_done    = if_done_q & ~if_flush;
   assign if_data    = if_data_q;
   assign mem_addr_a = addr_a_q;

   // ---------------- load/store path ----------------
   ls_state_t      ls_state, ls_state_nx;
   logic [AW-1:0]  addr_b_q, addr_b_nx;
   logic [DW-1:0]  src_b_q, src_b_nx;
   logic [DW-1:0]  rdata_q, rdata_nx;
   logic           wr_q, wr_nx;
   logic           ls_done_q, ls_done_nx;
   logic           ls_io, ls_sub, ls_direct;
   logic [DW-1:0]  load_c, merge_c;

   assign ls_io     = (ls_addr[IO_HI:IO_LO] == IO_TAG);
   assign ls_sub    = (ls_width == WIDTH_B) || (ls_width == WIDTH_H);
   // Word stores and all IO stores write straight through without a read
   assign ls_direct = ls_we && (ls_io || !ls_sub);

   mem_ctrl_ls_align u_align (
      .width   (ls_width),
      .sgn     (ls_signed),
      .io      (ls_io),
      .offset  (ls_addr[1:0]),
      .word    (mem_data_b),
      .wdata   (ls_wdata),
      .load_c  (load_c),
      .merge_c (merge_c)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in)   ls_state <= LS_IDLE;
      else if (run) ls_state <= ls_state_nx;
   end

   always_comb begin
      ls_state_nx = ls_state;
      case (ls_state)
         LS_IDLE:  if (ls_valid) ls_state_nx = ls_direct ? LS_WR : LS_RD;
         LS_RD:    ls_state_nx = ls_we ? LS_MERGE : LS_DONE;
         LS_MERGE: ls_state_nx = LS_DONE;
         LS_WR:    ls_state_nx = LS_IDLE;
         LS_DONE:  ls_state_nx = LS_IDLE;
         default:  ls_state_nx = LS_IDLE;
      endcase
   end

   always_comb begin
      addr_b_nx  = addr_b_q;
      src_b_nx   = src_b_q;
      rdata_nx   = rdata_q;
      wr_nx      = 1'b0;
      ls_done_nx = 1'b0;
      case (ls_state)
         LS_IDLE: if (ls_valid) begin
            addr_b_nx = {2'b00, ls_addr[AW-1:2]};
            if (ls_direct) begin
               wr_nx      = 1'b1;
               ls_done_nx = 1'b1;
               src_b_nx   = ls_wdata;
               rdata_nx   = '0;
            end
         end
         LS_RD: begin
            if (ls_we) begin
               wr_nx    = 1'b1;
               src_b_nx = merge_c;
            end else begin
               rdata_nx   = load_c;
               ls_done_nx = 1'b1;
            end
         end
         LS_MERGE: begin
            ls_done_nx = 1'b1;
            rdata_nx   = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         addr_b_q  <= '0;
         src_b_q   <= '0;
         rdata_q   <= '0;
         wr_q      <= 1'b0;
         ls_done_q <= 1'b0;
      end else if (run) begin
         addr_b_q  <= addr_b_nx;
         src_b_q   <= src_b_nx;
         rdata_q   <= rdata_nx;
         wr_q      <= wr_nx;
         ls_done_q <= ls_done_nx;
      end
   end

`ifdef MEM_CTRL_RDY_EN
   assign mem_wr_b = wr_q & rdy_in;
`else
   assign mem_wr_b = wr_q;
`endif
   assign mem_src_b  = src_b_q;
   assign mem_addr_b = addr_b_q;
   assign ls_done    = ls_done_q;
   assign ls_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed cases plus random fetch/load/store traffic
// against a word-array reference model. Exercises rdy_in when MEM_CTRL_RDY_EN is defined.
module tb_mem_ctrl;

   localparam int STALL_LEN = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_valid = 1'b0, if_flush = 1'b0, if_done;
   logic [31:0] if_addr = '0, if_data;
   logic        ls_valid = 1'b0, ls_we = 1'b0, ls_signed = 1'b0, ls_done;
   logic [1:0]  ls_width = 2'b00;
   logic [31:0] ls_addr = '0, ls_wdata = '0, ls_rdata;
   logic [31:0] mem_addr_a, mem_data_a, mem_src_b, mem_addr_b, mem_data_b;
   logic        mem_wr_b;
`ifdef MEM_CTRL_RDY_EN
   logic        rdy = 1'b1;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk_in     (clk),
      .rst_in     (rst),
`ifdef MEM_CTRL_RDY_EN
      .rdy_in     (rdy),
`endif
      .if_valid   (if_valid),
      .if_addr    (if_addr),
      .if_flush   (if_flush),
      .if_done    (if_done),
      .if_data    (if_data),
      .ls_valid   (ls_valid),
      .ls_we      (ls_we),
      .ls_width   (ls_width),
      .ls_signed  (ls_signed),
      .ls_addr    (ls_addr),
      .ls_wdata   (ls_wdata),
      .ls_done    (ls_done),
      .ls_rdata   (ls_rdata),
      .mem_addr_a (mem_addr_a),
      .mem_data_a (mem_data_a),
      .mem_wr_b   (mem_wr_b),
      .mem_src_b  (mem_src_b),
      .mem_addr_b (mem_addr_b),
      .mem_data_b (mem_data_b)
   );

   // Bench RAM (1K words) plus a 16-word IO window; reads follow the registered address
   logic [31:0] ram    [1024];
   logic [31:0] io_mem [16];
   logic [31:0] m_ram  [1024];
   logic [31:0] m_io   [16];
   logic        ld_en = 1'b0, ld_io = 1'b0;
   logic [9:0]  ld_idx = '0;
   logic [31:0] ld_val = '0;

   assign mem_data_a = (mem_addr_a[15:14] == 2'b11) ? io_mem[mem_addr_a[3:0]] : ram[mem_addr_a[9:0]];
   assign mem_data_b = (mem_addr_b[15:14] == 2'b11) ? io_mem[mem_addr_b[3:0]] : ram[mem_addr_b[9:0]];

   always @(posedge clk) begin
      if (ld_en) begin
         if (ld_io) io_mem[ld_idx[3:0]] <= ld_val;
         else       ram[ld_idx]         <= ld_val;
      end else if (mem_wr_b) begin
         if (mem_addr_b[15:14] == 2'b11) io_mem[mem_addr_b[3:0]] <= mem_src_b;
         else                            ram[mem_addr_b[9:0]]    <= mem_src_b;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic poke(input bit io, input int idx, input logic [31:0] v);
      @(negedge clk);
      ld_en  = 1'b1;
      ld_io  = io;
      ld_idx = 10'(idx);
      ld_val = v;
      if (io) m_io[idx % 16] = v;
      else    m_ram[idx % 1024] = v;
   endtask

   // Reference lane: byte uses addr%4, half rounds down to even, word and IO use lane 0
   function automatic int lane(input logic [1:0] w, input logic [31:0] a, input bit io);
      if (io)          return 0;
      if (w == 2'b00)  return int'(a % 4);
      if (w == 2'b01)  return int'((a % 4) / 2) * 2;
      return 0;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [31:0] a,
                                            input logic [1:0] w, input logic s, input bit io);
      logic [31:0] v;
      v = word >> (8 * lane(w, a, io));
      if (w == 2'b00) begin
         v = v % 256;
         if (s && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (w == 2'b01) begin
         v = v % 65536;
         if (s && v >= 32768) v = v + 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [31:0] a, input logic [1:0] w);
      int          k;
      logic [31:0] msk;
      k   = 8 * lane(w, a, 1'b0);
      msk = ((w == 2'b00) ? 32'hFF : 32'hFFFF) << k;
      return (old & ~msk) | ((wd << k) & msk);
   endfunction

   task automatic fetch(input logic [31:0] a);
      int          n;
      logic [31:0] exp;
      exp = m_ram[a[11:2]];
      @(negedge clk);
      if_valid = 1'b1;
      if_addr  = a;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!if_done && n < 10);
      if_valid = 1'b0;
      chk("if_latency", 32'(n), 32'd2);
      chk("if_mem_addr_a", mem_addr_a, a >> 2);
      chk("if_data", if_data, exp);
   endtask

   // One load/store; stall_at>0 drops rdy_in for STALL_LEN cycles from that cycle on
   task automatic ls_op(input logic we, input logic [1:0] w, input logic s,
                        input logic [31:0] a, input logic [31:0] wd, input int stall_at);
      bit          io;
      int          n, lat, wrs, exp_wr;
      logic [31:0] wa, old, exp_rd, exp_src, got_src, got_wa;
      io      = (a[17:16] == 2'b11);
      wa      = a >> 2;
      old     = io ? m_io[wa[3:0]] : m_ram[wa[9:0]];
      exp_rd  = '0;
      exp_src = '0;
      if (!we) begin
         lat = 2; exp_wr = 0; exp_rd = exp_load(old, a, w, s, io);
      end else if (io || w == 2'b10) begin
         lat = 1; exp_wr = 1; exp_src = wd;
      end else begin
         lat = 3; exp_wr = 1; exp_src = exp_merge(old, wd, a, w);
      end
      if (stall_at > 0) lat += STALL_LEN;
      @(negedge clk);
      ls_valid = 1'b1; ls_we = we; ls_width = w; ls_signed = s; ls_addr = a; ls_wdata = wd;
      n = 0; wrs = 0; got_src = '0; got_wa = '0;
      do begin
         @(negedge clk);
         n++;
`ifdef MEM_CTRL_RDY_EN
         if (stall_at > 0 && n == stall_at) rdy = 1'b0;
         if (stall_at > 0 && n == stall_at + STALL_LEN) rdy = 1'b1;
`endif
         #1;
         if (mem_wr_b) begin
            wrs++;
            got_src = mem_src_b;
            got_wa  = mem_addr_b;
         end
      end while (!ls_done && n < 14);
      ls_valid = 1'b0;
      chk("ls_latency", 32'(n), 32'(lat));
      chk("ls_rdata", ls_rdata, exp_rd);
      chk("ls_write_count", 32'(wrs), 32'(exp_wr));
      if (exp_wr != 0) begin
         chk("ls_write_data", got_src, exp_src);
         chk("ls_write_addr", got_wa, wa);
         if (io) m_io[wa[3:0]] = exp_src;
         else    m_ram[wa[9:0]] = exp_src;
      end
   endtask

   initial begin
      int          seen, mask;
      logic [31:0] a;
      logic [1:0]  w;

      // Preload RAM while reset is held
      for (int i = 0; i < 1024; i++) poke(1'b0, i, $urandom);
      for (int i = 0; i < 16; i++)   poke(1'b1, i, $urandom);
      poke(1'b0, 'h41, 32'hDEAD_BEEF);
      poke(1'b0, 'h80, 32'h8011_2233);
      poke(1'b0, 'h40, 32'h1122_3344);
      @(negedge clk);
      ld_en = 1'b0;
      chk("rst_strobes", {29'd0, if_done, ls_done, mem_wr_b}, 32'd0);
      chk("rst_ls_rdata", ls_rdata, 32'd0);
      chk("rst_buses", mem_addr_a | mem_addr_b | mem_src_b | if_data, 32'd0);
      rst = 1'b0;

      fetch(32'h104);
      ls_op(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 0);
      ls_op(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 0);
      ls_op(1'b0, 2'b01, 1'b1, 32'h203, 32'h0, 0);
      ls_op(1'b0, 2'b10, 1'b0, 32'h203, 32'h0, 0);
      ls_op(1'b1, 2'b00, 1'b0, 32'h101, 32'hAB, 0);
      ls_op(1'b1, 2'b00, 1'b0, 32'h30000, 32'h41, 0);
      ls_op(1'b0, 2'b00, 1'b0, 32'h30002, 32'h0, 0);

      // Flush while waiting on RAM: no pulse, then a normal fetch
      @(negedge clk);
      if_valid = 1'b1; if_addr = 32'h300;
      @(negedge clk);
      if_flush = 1'b1; if_valid = 1'b0;
      @(negedge clk);
      if_flush = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (if_done) seen = 1;
         @(negedge clk);
      end
      chk("flush_wait_no_done", 32'(seen), 32'd0);
      fetch(32'h200);

      // Flush together with a request in idle drops it
      if_valid = 1'b1; if_flush = 1'b1; if_addr = 32'h104;
      @(negedge clk);
      if_valid = 1'b0; if_flush = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         if (if_done) seen = 1;
         @(negedge clk);
      end
      chk("flush_idle_no_done", 32'(seen), 32'd0);

      // Held request: one completion every third cycle
      if_valid = 1'b1; if_addr = 32'h104;
      mask = 0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (if_done) mask |= (1 << i);
      end
      if_valid = 1'b0;
      chk("fetch_back_to_back", 32'(mask), 32'h124);

      // Reset in the merge-write cycle of a half store to 0x106
      @(negedge clk);
      ls_valid = 1'b1; ls_we = 1'b1; ls_width = 2'b01; ls_signed = 1'b0;
      ls_addr = 32'h106; ls_wdata = 32'h0000_1234;
      @(negedge clk);
      @(negedge clk);
      chk("rmw_write_cycle", {31'd0, mem_wr_b}, 32'd1);
      chk("rmw_write_data", mem_src_b, 32'h1234_BEEF);
      rst = 1'b1;
      m_ram['h41] = 32'h1234_BEEF;
      @(negedge clk);
      chk("rst_rmw_wr", {31'd0, mem_wr_b}, 32'd0);
      chk("rst_rmw_done", {31'd0, ls_done}, 32'd0);
      rst = 1'b0; ls_valid = 1'b0;
      @(negedge clk);
      chk("rst_rmw_done_after", {31'd0, ls_done}, 32'd0);
      ls_op(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 0);
      fetch(32'h104);

`ifdef MEM_CTRL_RDY_EN
      ls_op(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 1);
      ls_op(1'b1, 2'b00, 1'b0, 32'h102, 32'h5A, 2);
      ls_op(1'b1, 2'b10, 1'b0, 32'h108, 32'hCAFE_F00D, 0);
`endif

      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            fetch(32'($urandom_range(0, 1023)) << 2);
         end else begin
            w = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) a = 32'h30000 + 32'($urandom_range(0, 63));
            else                           a = 32'($urandom_range(0, 4095));
            ls_op(1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)), a, $urandom, 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
